// File: rtl/skitter_meas_ctrl.sv
// Measurement sequencer for the skitter edge-position path: clear, settle, acquire, then stream out bins.
// Optional build macro SKITTER_SAT_FLAG_EN adds sat_flag and early ACQ exit on delay-line overrun.
module skitter_meas_ctrl #(
    parameter int NUM_BINS = 11,
    parameter int CNT_W    = 5,
    parameter int CODE_W   = 6,
    parameter int CODE_LO  = 17,
    parameter int CODE_HI  = 38,
    parameter int SAMP_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_settle,
    input  logic [SAMP_W-1:0] cfg_samples,
    input  logic [CODE_W-1:0] en_in,
    input  logic [CNT_W-1:0]  bin_cnt,
    output logic              hist_clr,
    output logic              hist_en,
    output logic [3:0]        bin_sel,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [3:0]        rd_bin,
    output logic [CNT_W-1:0]  rd_count,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] edge_min,
    output logic [CODE_W-1:0] edge_max,
    output logic              err,
`ifdef SKITTER_SAT_FLAG_EN
    output logic              sat_flag,
`endif
    output logic [2:0]        dbg_state
);

    // Readout handshake: a word moves on any cycle where rd_valid && rd_ready are both high;
    // rd_bin/rd_count stay frozen while rd_valid is high and rd_ready is low.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SETTLE = 3'd2,
        ACQ    = 3'd3,
        LOAD   = 3'd4,
        OUT    = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam logic [CODE_W-1:0] CODE_LO_C  = CODE_W'(CODE_LO);
    localparam logic [CODE_W-1:0] CODE_HI_C  = CODE_W'(CODE_HI);
    localparam logic [3:0]        LAST_BIN_C = 4'(NUM_BINS - 1);
    localparam logic [SAMP_W-1:0] ONE_C      = SAMP_W'(1);

    state_t              state_q, state_d;
    logic [7:0]          settle_q, settle_d;
    logic [SAMP_W-1:0]   samples_q, samples_d;
    logic [SAMP_W-1:0]   cnt_q, cnt_d;
    logic [3:0]          bin_sel_q, bin_sel_d;
    logic [3:0]          rd_bin_q, rd_bin_d;
    logic [CNT_W-1:0]    rd_count_q, rd_count_d;
    logic [CODE_W-1:0]   edge_min_q, edge_min_d;
    logic [CODE_W-1:0]   edge_max_q, edge_max_d;
    logic                err_q, err_d;
`ifdef SKITTER_SAT_FLAG_EN
    localparam logic [CODE_W-1:0] CODE_OVR_C = CODE_W'(CODE_HI + 1);
    logic                sat_q, sat_d;
    logic [1:0]          ovr_q, ovr_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_q   <= '0;
            samples_q  <= '0;
            cnt_q      <= '0;
            bin_sel_q  <= '0;
            rd_bin_q   <= '0;
            rd_count_q <= '0;
            edge_min_q <= '1;
            edge_max_q <= '0;
            err_q      <= 1'b0;
`ifdef SKITTER_SAT_FLAG_EN
            sat_q      <= 1'b0;
            ovr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            samples_q  <= samples_d;
            cnt_q      <= cnt_d;
            bin_sel_q  <= bin_sel_d;
            rd_bin_q   <= rd_bin_d;
            rd_count_q <= rd_count_d;
            edge_min_q <= edge_min_d;
            edge_max_q <= edge_max_d;
            err_q      <= err_d;
`ifdef SKITTER_SAT_FLAG_EN
            sat_q      <= sat_d;
            ovr_q      <= ovr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        samples_d  = samples_q;
        cnt_d      = cnt_q;
        bin_sel_d  = bin_sel_q;
        rd_bin_d   = rd_bin_q;
        rd_count_d = rd_count_q;
        edge_min_d = edge_min_q;
        edge_max_d = edge_max_q;
        err_d      = err_q;
`ifdef SKITTER_SAT_FLAG_EN
        sat_d      = sat_q;
        ovr_d      = ovr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    settle_d  = cfg_settle;
                    samples_d = cfg_samples;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                edge_min_d = '1;
                edge_max_d = '0;
                err_d      = 1'b0;
                bin_sel_d  = '0;
`ifdef SKITTER_SAT_FLAG_EN
                sat_d      = 1'b0;
                ovr_d      = '0;
`endif
                if (settle_q != 8'd0) begin
                    cnt_d   = SAMP_W'(settle_q);
                    state_d = SETTLE;
                end else if (samples_q != '0) begin
                    cnt_d   = samples_q;
                    state_d = ACQ;
                end else begin
                    state_d = LOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == ONE_C) begin
                    cnt_d   = samples_q;
                    state_d = (samples_q != '0) ? ACQ : LOAD;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            ACQ: begin
                if (en_in >= CODE_LO_C && en_in <= CODE_HI_C) begin
                    if (en_in < edge_min_q) edge_min_d = en_in;
                    if (en_in > edge_max_q) edge_max_d = en_in;
                end else begin
                    err_d = 1'b1;
                end
                cnt_d = cnt_q - ONE_C;
                if (cnt_q == ONE_C) state_d = LOAD;
`ifdef SKITTER_SAT_FLAG_EN
                // Four consecutive overrun codes mean the edge fell off the delay line.
                if (en_in == CODE_OVR_C) begin
                    if (ovr_q == 2'd3) state_d = LOAD;
                    else               ovr_d   = ovr_q + 2'd1;
                end else begin
                    ovr_d = '0;
                end
`endif
            end
            LOAD: begin
                rd_bin_d   = bin_sel_q;
                rd_count_d = bin_cnt;
                state_d    = OUT;
            end
            OUT: begin
`ifdef SKITTER_SAT_FLAG_EN
                if (rd_count_q == '1) sat_d = 1'b1;
`endif
                if (rd_ready) begin
                    if (bin_sel_q == LAST_BIN_C) begin
                        state_d = DONE;
                    end else begin
                        bin_sel_d = bin_sel_q + 4'd1;
                        state_d   = LOAD;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort wins over everything; run results stay as they were.
        if (abort) begin
            state_d    = IDLE;
            edge_min_d = edge_min_q;
            edge_max_d = edge_max_q;
            err_d      = err_q;
`ifdef SKITTER_SAT_FLAG_EN
            sat_d      = sat_q;
`endif
        end
    end

    assign hist_clr  = (state_q == CLEAR);
    assign hist_en   = (state_q == ACQ);
    assign rd_valid  = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign bin_sel   = bin_sel_q;
    assign rd_bin    = rd_bin_q;
    assign rd_count  = rd_count_q;
    assign edge_min  = edge_min_q;
    assign edge_max  = edge_max_q;
    assign err       = err_q;
    assign dbg_state = state_q;
`ifdef SKITTER_SAT_FLAG_EN
    assign sat_flag  = sat_q;
`endif

endmodule

// File: tb/tb_skitter_meas_ctrl.sv
// Bench for skitter_meas_ctrl: directed runs plus randomized runs checked against a phase-level model.
module tb_skitter_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_settle;
  logic [15:0] cfg_samples;
  logic [5:0]  en_in;
  logic [4:0]  bin_cnt;
  logic        hist_clr;
  logic        hist_en;
  logic [3:0]  bin_sel;
  logic        rd_valid;
  logic        rd_ready;
  logic [3:0]  rd_bin;
  logic [4:0]  rd_count;
  logic        busy;
  logic        done;
  logic [5:0]  edge_min;
  logic [5:0]  edge_max;
  logic        err;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Histogram stand-in: each run gets fresh random bin contents.
  logic [4:0] hist_mem [16];
  logic [5:0] code_q[$];

  assign bin_cnt = hist_mem[bin_sel];

  skitter_meas_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_settle(cfg_settle), .cfg_samples(cfg_samples),
    .en_in(en_in), .bin_cnt(bin_cnt),
    .hist_clr(hist_clr), .hist_en(hist_en), .bin_sel(bin_sel),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_bin(rd_bin), .rd_count(rd_count),
    .busy(busy), .done(done),
    .edge_min(edge_min), .edge_max(edge_max), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_hist_clr"}, 32'(hist_clr), 32'd0);
    check({tag, "_hist_en"},  32'(hist_en),  32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
    check({tag, "_bin_sel"},  32'(bin_sel),  32'd0);
    check({tag, "_rd_bin"},   32'(rd_bin),   32'd0);
    check({tag, "_rd_count"}, 32'(rd_count), 32'd0);
    check({tag, "_edge_min"}, 32'(edge_min), 32'h3F);
    check({tag, "_edge_max"}, 32'(edge_max), 32'd0);
  endtask

  // ---------------- run driver + model ----------------
  // ready_mode: 0 always ready, 1 random, 2 hold ready low 5 cycles on bin 3.
  // abort_acq: 0 none, else abort during that ACQ cycle.
  task automatic run(input string tag, input int settle, input int samples,
                     input int ready_mode, input int abort_acq);
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [5:0] acq_q[$];
    int cyc, clr_cnt, clr_cyc, first_en, en_cnt, first_valid, done_cnt;
    int stall_left, stall_err, gap_err, code_i;
    logic prev_stall, prev_xfer, finished;
    logic [3:0] prev_bin;
    logic [4:0] prev_cnt;
    logic [5:0] exp_min, exp_max;
    logic exp_err;

    for (int k = 0; k < 16; k++) hist_mem[k] = 5'($urandom_range(0, 31));
    hist_mem[$urandom_range(0, 10)] = 5'd31;
    for (int k = 0; k < 11; k++) exp_q.push_back({4'(k), hist_mem[k]});

    clr_cnt = 0; clr_cyc = -1; first_en = -1; en_cnt = 0; first_valid = -1;
    done_cnt = 0; stall_left = 5; stall_err = 0; gap_err = 0; code_i = 0;
    prev_stall = 1'b0; prev_xfer = 1'b0; prev_bin = '0; prev_cnt = '0; finished = 1'b0;

    start = 1'b1;
    cfg_settle = 8'(settle);
    cfg_samples = 16'(samples);
    tick();
    cyc = 1;
    while (cyc < 3000 && !finished) begin
      // start while busy must be ignored
      start = 1'($urandom_range(0, 1));
      cfg_settle = 8'($urandom);
      cfg_samples = 16'($urandom);
      en_in = (code_i < code_q.size()) ? code_q[code_i] : 6'($urandom_range(10, 45));
      case (ready_mode)
        0: rd_ready = 1'b1;
        1: rd_ready = 1'($urandom_range(0, 1));
        default: begin
          rd_ready = 1'b1;
          if (rd_valid && rd_bin == 4'd3 && stall_left > 0) begin
            rd_ready = 1'b0;
            stall_left--;
          end
        end
      endcase
      if (hist_clr) begin
        clr_cnt++;
        if (clr_cyc < 0) clr_cyc = cyc;
      end
      if (hist_en) begin
        if (first_en < 0) first_en = cyc;
        acq_q.push_back(en_in);
        en_cnt++;
        code_i++;
        if (abort_acq != 0 && en_cnt == abort_acq) abort = 1'b1;
      end
      if (done) done_cnt++;
      if (rd_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && !(rd_valid && rd_bin == prev_bin && rd_count == prev_cnt)) stall_err++;
      if (prev_xfer && rd_valid) gap_err++;
      if (rd_valid && rd_ready) got_q.push_back({rd_bin, rd_count});
      prev_stall = rd_valid && !rd_ready;
      prev_xfer = rd_valid && rd_ready;
      prev_bin = rd_bin;
      prev_cnt = rd_count;
      tick();
      abort = 1'b0;
      cyc++;
      if (!busy) finished = 1'b1;
    end
    start = 1'b0;
    rd_ready = 1'b0;
    check({tag, "_terminated"}, 32'(finished), 32'd1);

    // Model: min/max/err from the codes presented during acquisition.
    exp_min = 6'h3F; exp_max = 6'h00; exp_err = 1'b0;
    foreach (acq_q[i]) begin
      if (acq_q[i] >= 6'd17 && acq_q[i] <= 6'd38) begin
        if (acq_q[i] < exp_min) exp_min = acq_q[i];
        if (acq_q[i] > exp_max) exp_max = acq_q[i];
      end else begin
        exp_err = 1'b1;
      end
    end

    check({tag, "_clr_cnt"}, 32'(clr_cnt), 32'd1);
    check({tag, "_clr_cyc"}, 32'(clr_cyc), 32'd1);
    check({tag, "_edge_min"}, 32'(edge_min), 32'(exp_min));
    check({tag, "_edge_max"}, 32'(edge_max), 32'(exp_max));
    check({tag, "_err"}, 32'(err), 32'(exp_err));

    if (abort_acq != 0) begin
      check({tag, "_abort_en_cnt"}, 32'(en_cnt), 32'(abort_acq));
      check({tag, "_abort_hist_en"}, 32'(hist_en), 32'd0);
      check({tag, "_abort_no_done"}, 32'(done_cnt), 32'd0);
      check({tag, "_abort_no_words"}, 32'(got_q.size()), 32'd0);
    end else begin
      check({tag, "_en_cnt"}, 32'(en_cnt), 32'(samples));
      if (samples > 0) check({tag, "_first_en"}, 32'(first_en), 32'(2 + settle));
      check({tag, "_first_valid"}, 32'(first_valid), 32'(3 + settle + samples));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_word_cnt"}, 32'(got_q.size()), 32'd11);
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        logic [8:0] e, g;
        e = exp_q.pop_front();
        g = got_q.pop_front();
        check({tag, "_word"}, 32'(g), 32'(e));
      end
      check({tag, "_stall_stable"}, 32'(stall_err), 32'd0);
      check({tag, "_valid_gap"}, 32'(gap_err), 32'd0);
      if (ready_mode == 2) check({tag, "_stall_seen"}, 32'(stall_left), 32'd0);
      // Stray start pulses during the run must not have re-armed it.
      tick();
      tick();
      check({tag, "_idle_after"}, 32'(busy), 32'd0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    cfg_settle = '0; cfg_samples = '0; en_in = '0;
    for (int k = 0; k < 16; k++) hist_mem[k] = '0;
    tick(); tick(); tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check_reset_vals("post_reset");

    code_q = {};
    for (int i = 0; i < 10; i++) code_q.push_back(6'd20);
    run("basic", 3, 10, 0, 0);

    code_q = {6'd17, 6'd38, 6'd25, 6'd40};
    run("minmax", int'($urandom_range(0, 3)), 4, 0, 0);

    code_q = {};
    run("stall", 2, 8, 2, 0);

    // Fifth code equals the first, so min/max are the same whether or not the abort cycle is sampled.
    code_q = {6'd20, 6'd45, 6'd30, 6'd25, 6'd20, 6'd20, 6'd20, 6'd20, 6'd20, 6'd20};
    run("abort", 1, 10, 0, 5);

    code_q = {};
    run("no_acq", 0, 0, 1, 0);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_clr", 32'(hist_clr), 32'd0);
    tick();
    check("start_abort_still_idle", 32'(busy), 32'd0);

    for (int r = 0; r < 5; r++) begin
      code_q = {};
      run("random", int'($urandom_range(0, 5)), int'($urandom_range(0, 30)),
          int'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of an acquisition with bad codes flowing.
    en_in = 6'd45;
    cfg_settle = 8'd0; cfg_samples = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrun_reset");
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
